pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the multi-cycle core; successor to the single-source PC register. It holds the instruction pointer and computes the next PC from six sources: sequential, PC-relative branch, absolute jump, call, return and trap return. A small circular return-address stack (RAS) supplies return targets, and a trap port with a saved exception PC (epc) redirects fetch. It sits between the control FSM, which drives `pc_write` and `pc_sel`, and instruction memory addressing.

## Interface
- PC_WIDTH, 64: width of PC, target, offset, epc.
- STEP, 1: sequential increment in address units; power of two.
- RAS_DEPTH, 4: return-stack entries; power of two, ≥2.
- RESET_VECTOR, 0: PC after reset or flush.
- TRAP_VECTOR, 'h40: PC loaded on trap.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous restart: PC ← RESET_VECTOR, RAS emptied.
- trap  in  1  take trap this cycle; independent of `pc_write`.
- pc_write  in  1  commit next PC this cycle.
- pc_sel  in  3  next-PC source: 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5 XRET, 6–7 reserved.
- target  in  PC_WIDTH  absolute target for JUMP and CALL.
- offset  in  PC_WIDTH  two's-complement offset for BRANCH.
- pc  out  PC_WIDTH  current instruction pointer.
- epc  out  PC_WIDTH  PC saved at last trap.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_underflow  out  1  one-cycle pulse: RET on empty RAS.
- sel_err  out  1  one-cycle pulse: reserved `pc_sel` with `pc_write`.
- misaligned  out  1  one-cycle pulse: committed PC not a multiple of STEP.

## Operation
- Per-edge priority: rst > flush > trap > pc_write > hold.
- rst: pc = RESET_VECTOR, epc = 0, RAS count = 0, all pulse outputs 0. Resulting flag state: ras_empty = 1, ras_full = 0.
- flush: pc = RESET_VECTOR, RAS count = 0; epc unchanged.
- trap: epc ← pc, pc ← TRAP_VECTOR; no RAS push or pop even if `pc_write` = 1.
- pc_write with pc_sel:
  - SEQ: pc + STEP.
  - BRANCH: pc + offset.
  - JUMP: target.
  - CALL: target; push pc + STEP.
  - RET: pop top of RAS. If empty: pc + STEP and pulse ras_underflow.
  - XRET: epc.
  - 6–7: pc holds; pulse sel_err.
- All PC arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- RAS is circular: push on full overwrites the oldest entry and count stays at RAS_DEPTH; ras_full stays 1.
- `misaligned` is evaluated on every committed pc value, including those from trap and flush. It is never asserted when STEP = 1.
- `pc_write` = 0 and no trap/flush: all state holds and pulses are 0.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- A new pc is visible the cycle after the edge on which it is committed.
- Pulses are high for exactly the cycle following the causing edge.
- RAS push or pop and the pc update occur on the same edge.
- Back-to-back CALL/RET on consecutive cycles is supported at full rate.

## Structure
- Package `pc_pkg`: `pc_sel_e` enum (SEQ, BRANCH, JUMP, CALL, RET, XRET) and its 3-bit width constant.
- Sub-module `return_stack`: parametrised circular LIFO. Ports: push, pop, push_data, top, empty, full, clear. Top pointer plus saturating count.
- pc_sequencer owns: next-PC mux, pc/epc registers, pulse registers.

## Test plan
- Reset, then 3 cycles of SEQ with STEP = 1 -> pc = 0, 1, 2, 3; ras_empty = 1.
- pc = 'h10, CALL target 'h80; then RET -> pc = 'h80, then 'h11; ras_empty returns to 1.
- 5 CALLs with RAS_DEPTH = 4 (return addrs A1..A5), then 5 RETs -> returns A5, A4, A3, A2; 5th RET gives pc + 1 with ras_underflow pulse.
- pc = 'h20, trap with pc_write = 1 and pc_sel = CALL -> pc = 'h40, epc = 'h20, RAS unchanged; then XRET -> pc = 'h20.
- pc = max value, SEQ -> pc = 0; BRANCH offset = −1 from pc = 0 -> pc = all ones.
- flush and trap in the same cycle -> pc = RESET_VECTOR, epc unchanged. pc_sel = 6 -> pc holds, sel_err pulses.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC source encoding for the PC sequencer
package pc_pkg;

   localparam int PC_SEL_W = 3;

   typedef enum logic [PC_SEL_W-1:0] {
      SEL_SEQ    = 3'd0,
      SEL_BRANCH = 3'd1,
      SEL_JUMP   = 3'd2,
      SEL_CALL   = 3'd3,
      SEL_RET    = 3'd4,
      SEL_XRET   = 3'd5
   } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// rtl/pc_sequencer_return_stack.sv - circular return-address LIFO with saturating count
module return_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] COUNT_MAX = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             wr_en;

   assign top   = mem_q[ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == COUNT_MAX);

   // A push on a full stack wraps onto the oldest slot; the count saturates.
   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      wr_en   = 1'b0;
      if (clear) begin
         ptr_d   = '0;
         count_d = '0;
      end else if (push) begin
         ptr_d = ptr_q + 1'b1;
         wr_en = 1'b1;
         if (!full) count_d = count_q + 1'b1;
      end else if (pop && !empty) begin
         ptr_d   = ptr_q - 1'b1;
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem_q[ptr_d] <= push_data;
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with six next-PC sources, RAS and trap/epc
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                  PC_WIDTH     = 64,
   parameter int                  STEP         = 1,
   parameter int                  RAS_DEPTH    = 4,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'('h40)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                trap,
   input  logic                pc_write,
   input  logic [PC_SEL_W-1:0] pc_sel,
   input  logic [PC_WIDTH-1:0] target,
   input  logic [PC_WIDTH-1:0] offset,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] epc,
   output logic                ras_empty,
   output logic                ras_full,
   output logic                ras_underflow,
   output logic                sel_err,
   output logic                misaligned
);

   localparam logic [PC_WIDTH-1:0] STEP_INC   = PC_WIDTH'(STEP);
   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(STEP - 1);

   logic [PC_WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, pc_step, ras_top;
   logic                ras_underflow_q, ras_underflow_d;
   logic                sel_err_q, sel_err_d;
   logic                misaligned_q, misaligned_d;
   logic                ras_push, ras_pop, ras_clear, commit;

   assign pc_step = pc_q + STEP_INC;

   always_comb begin
      pc_d            = pc_q;
      epc_d           = epc_q;
      ras_push        = 1'b0;
      ras_pop         = 1'b0;
      ras_clear       = 1'b0;
      ras_underflow_d = 1'b0;
      sel_err_d       = 1'b0;
      commit          = 1'b0;
      if (flush) begin
         pc_d      = RESET_VECTOR;
         ras_clear = 1'b1;
         commit    = 1'b1;
      end else if (trap) begin
         epc_d  = pc_q;
         pc_d   = TRAP_VECTOR;
         commit = 1'b1;
      end else if (pc_write) begin
         commit = 1'b1;
         case (pc_sel)
            SEL_SEQ:    pc_d = pc_step;
            SEL_BRANCH: pc_d = pc_q + offset;
            SEL_JUMP:   pc_d = target;
            SEL_CALL: begin
               pc_d     = target;
               ras_push = 1'b1;
            end
            SEL_RET: begin
               if (ras_empty) begin
                  pc_d            = pc_step;
                  ras_underflow_d = 1'b1;
               end else begin
                  pc_d    = ras_top;
                  ras_pop = 1'b1;
               end
            end
            SEL_XRET:   pc_d = epc_q;
            default: begin
               sel_err_d = 1'b1;
               commit    = 1'b0;
            end
         endcase
      end
      misaligned_d = commit && ((pc_d & ALIGN_MASK) != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q            <= RESET_VECTOR;
         epc_q           <= '0;
         ras_underflow_q <= 1'b0;
         sel_err_q       <= 1'b0;
         misaligned_q    <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         epc_q           <= epc_d;
         ras_underflow_q <= ras_underflow_d;
         sel_err_q       <= sel_err_d;
         misaligned_q    <= misaligned_d;
      end
   end

   return_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (PC_WIDTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .clear     (ras_clear),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_step),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

   assign pc            = pc_q;
   assign epc           = epc_q;
   assign ras_underflow = ras_underflow_q;
   assign sel_err       = sel_err_q;
   assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
   import pc_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, trap, pc_write;
   logic [2:0]  pc_sel;
   logic [63:0] target, offset, pc, epc;
   logic        ras_empty, ras_full, ras_underflow, sel_err, misaligned;

   logic        b_flush, b_trap, b_pc_write;
   logic [2:0]  b_pc_sel;
   logic [15:0] b_target, b_offset, b_pc, b_epc;
   logic        b_ras_empty, b_ras_full, b_ras_underflow, b_sel_err, b_misaligned;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_sequencer u_dut (
      .clk(clk), .rst(rst), .flush(flush), .trap(trap), .pc_write(pc_write),
      .pc_sel(pc_sel), .target(target), .offset(offset), .pc(pc), .epc(epc),
      .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow),
      .sel_err(sel_err), .misaligned(misaligned)
   );

   pc_sequencer #(.PC_WIDTH(16), .STEP(4)) u_dut4 (
      .clk(clk), .rst(rst), .flush(b_flush), .trap(b_trap), .pc_write(b_pc_write),
      .pc_sel(b_pc_sel), .target(b_target), .offset(b_offset), .pc(b_pc), .epc(b_epc),
      .ras_empty(b_ras_empty), .ras_full(b_ras_full), .ras_underflow(b_ras_underflow),
      .sel_err(b_sel_err), .misaligned(b_misaligned)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; trap = 1'b0; pc_write = 1'b0;
      pc_sel = SEL_SEQ; target = '0; offset = '0;
      b_flush = 1'b0; b_trap = 1'b0; b_pc_write = 1'b0;
      b_pc_sel = SEL_SEQ; b_target = '0; b_offset = '0;
      step();
      rst = 1'b0;
      check("rst_pc", pc, 64'h0);
      check("rst_epc", epc, 64'h0);
      check("rst_empty", ras_empty, 1'b1);
      check("rst_full", ras_full, 1'b0);
      check("rst_pulses", {ras_underflow, sel_err, misaligned}, 3'b000);

      pc_write = 1'b1; pc_sel = SEL_SEQ;
      step(); check("seq1", pc, 64'h1);
      step(); check("seq2", pc, 64'h2);
      step(); check("seq3", pc, 64'h3);
      check("seq_empty", ras_empty, 1'b1);

      pc_sel = SEL_JUMP; target = 64'h10;
      step(); check("jump10", pc, 64'h10);
      pc_sel = SEL_CALL; target = 64'h80;
      step(); check("call_pc", pc, 64'h80);
      check("call_nonempty", ras_empty, 1'b0);
      pc_sel = SEL_RET;
      step(); check("ret_pc", pc, 64'h11);
      check("ret_empty", ras_empty, 1'b1);

      pc_sel = SEL_CALL;
      target = 64'h100; step(); check("c1", pc, 64'h100);
      target = 64'h200; step(); check("c2", pc, 64'h200);
      target = 64'h300; step(); check("c3", pc, 64'h300);
      target = 64'h400; step(); check("c4_full", ras_full, 1'b1);
      target = 64'h500; step(); check("c5_pc", pc, 64'h500);
      check("c5_full", ras_full, 1'b1);
      pc_sel = SEL_RET;
      step(); check("r1", pc, 64'h401);
      check("r1_notfull", ras_full, 1'b0);
      step(); check("r2", pc, 64'h301);
      step(); check("r3", pc, 64'h201);
      step(); check("r4", pc, 64'h101);
      check("r4_empty", ras_empty, 1'b1);
      check("r4_noflow", ras_underflow, 1'b0);
      step(); check("r5_pc", pc, 64'h102);
      check("r5_underflow", ras_underflow, 1'b1);
      pc_write = 1'b0;
      step(); check("idle_pc", pc, 64'h102);
      check("idle_underflow", ras_underflow, 1'b0);

      pc_write = 1'b1; pc_sel = SEL_JUMP; target = 64'h20;
      step();
      trap = 1'b1; pc_sel = SEL_CALL; target = 64'h999;
      step(); check("trap_pc", pc, 64'h40);
      check("trap_epc", epc, 64'h20);
      check("trap_noras", ras_empty, 1'b1);
      trap = 1'b0; pc_sel = SEL_XRET;
      step(); check("xret_pc", pc, 64'h20);

      pc_sel = SEL_JUMP; target = '1;
      step(); check("max_pc", pc, 64'hFFFF_FFFF_FFFF_FFFF);
      pc_sel = SEL_SEQ;
      step(); check("wrap_seq", pc, 64'h0);
      pc_sel = SEL_BRANCH; offset = '1;
      step(); check("branch_neg", pc, 64'hFFFF_FFFF_FFFF_FFFF);
      pc_sel = SEL_BRANCH; offset = 64'h31;
      step(); check("branch_pos", pc, 64'h30);

      pc_sel = SEL_CALL; target = 64'h70;
      step(); check("pre_flush_ras", ras_empty, 1'b0);
      flush = 1'b1; trap = 1'b1;
      step(); check("flush_pc", pc, 64'h0);
      check("flush_epc", epc, 64'h20);
      check("flush_empty", ras_empty, 1'b1);
      flush = 1'b0; trap = 1'b0;

      pc_sel = SEL_JUMP; target = 64'h55;
      step();
      pc_sel = 3'd6;
      step(); check("sel6_pc", pc, 64'h55);
      check("sel6_err", sel_err, 1'b1);
      pc_sel = 3'd7;
      step(); check("sel7_err", sel_err, 1'b1);
      pc_write = 1'b0;
      step(); check("sel_err_clear", sel_err, 1'b0);
      check("step1_nomis", misaligned, 1'b0);

      b_pc_write = 1'b1; b_pc_sel = SEL_JUMP; b_target = 16'h13;
      step(); check("b_jump_pc", b_pc, 16'h13);
      check("b_jump_mis", b_misaligned, 1'b1);
      b_pc_sel = SEL_SEQ;
      step(); check("b_seq_pc", b_pc, 16'h17);
      check("b_seq_mis", b_misaligned, 1'b1);
      b_flush = 1'b1;
      step(); check("b_flush_mis", b_misaligned, 1'b0);
      b_flush = 1'b0; b_pc_sel = SEL_JUMP; b_target = 16'h8;
      step(); check("b_aligned_mis", b_misaligned, 1'b0);
      b_pc_sel = SEL_SEQ;
      step(); check("b_seq4_pc", b_pc, 16'hC);
      b_pc_write = 1'b0;
      step(); check("b_hold_mis", b_misaligned, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
